// File: rtl/seq_detector.sv
// Symbol-stream sequence identifier. It hunts for the start of one of four
// fixed symbol sequences, narrows the candidates as symbols arrive, then
// locks on the single survivor and follows it until a symbol mismatches.

// One table entry: given a candidate's current position, produce the next
// position (with wrap-around), the symbol expected there, the symbol at
// position 0, and whether the next position is the last one.
module seq_cand #(
  parameter int K = 0
) (
  input  logic [3:0] ph,
  output logic [3:0] ph_nxt,
  output logic [1:0] sym_nxt,
  output logic [1:0] sym0,
  output logic       at_end
);
  // Symbols are packed two bits per position, position 0 in the LSBs.
  localparam logic [31:0] TBL  = (K == 0) ? 32'h0069_E3CB :
                                 (K == 1) ? 32'h0000_002D :
                                 (K == 2) ? 32'h0000_03A6 : 32'h0000_0009;
  localparam logic [3:0]  LAST = (K == 0) ? 4'd11 :
                                 (K == 1) ? 4'd3  :
                                 (K == 2) ? 4'd5  : 4'd1;

  // Advance position with wrap and look up the symbols.
  always_comb begin
    ph_nxt  = (ph >= LAST) ? 4'd0 : ph + 4'd1;
    sym_nxt = TBL[{ph_nxt, 1'b0} +: 2];
    sym0    = TBL[1:0];
    at_end  = (ph_nxt == LAST);
  end
endmodule

module seq_detector (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] z,
  input  logic       z_valid,
  output logic [1:0] sel,
  output logic       locked,
  output logic [3:0] phase,
  output logic       frame_done,
  output logic       err
);
  localparam int NUM_SEQ = 4;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    TRACK = 2'd1,
    LOCK  = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [NUM_SEQ-1:0]       mask_q, mask_d;
  logic [NUM_SEQ-1:0][3:0]  cph_q, cph_d;
  logic [1:0]               sel_q, sel_d;
  logic                     locked_q, locked_d;
  logic [3:0]               phase_q, phase_d;
  logic                     frame_done_q, frame_done_d;
  logic                     err_q, err_d;

  logic [NUM_SEQ-1:0][3:0]  ph_nxt;
  logic [NUM_SEQ-1:0][1:0]  sym_nxt;
  logic [NUM_SEQ-1:0][1:0]  sym0;
  logic [NUM_SEQ-1:0]       at_end;
  logic [NUM_SEQ-1:0]       hit0;
  logic [NUM_SEQ-1:0]       surv;
  logic [1:0]               surv_idx;

  for (genvar g = 0; g < NUM_SEQ; g++) begin : g_cand
    seq_cand #(.K(g)) u_cand (
      .ph      (cph_q[g]),
      .ph_nxt  (ph_nxt[g]),
      .sym_nxt (sym_nxt[g]),
      .sym0    (sym0[g]),
      .at_end  (at_end[g])
    );
  end

  // Per-candidate matches: start-of-sequence hits and surviving candidates.
  always_comb begin
    hit0     = '0;
    surv     = '0;
    surv_idx = 2'd0;
    for (int k = 0; k < NUM_SEQ; k++) begin
      hit0[k] = (sym0[k] == z);
      surv[k] = mask_q[k] && (sym_nxt[k] == z);
      if (surv[k]) surv_idx = 2'(k);
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    cph_d        = cph_q;
    sel_d        = sel_q;
    locked_d     = locked_q;
    phase_d      = phase_q;
    frame_done_d = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      HUNT: begin
        if (z_valid) begin
          mask_d = hit0;
          cph_d  = '0;
          if (|hit0) state_d = TRACK;
        end
      end
      TRACK: begin
        if (z_valid) begin
          mask_d = surv;
          cph_d  = ph_nxt;
          if (surv == '0) begin
            // The offending symbol is dropped, not reused as a new start.
            state_d = HUNT;
            err_d   = 1'b1;
          end else if ($onehot(surv) && at_end[surv_idx]) begin
            state_d      = LOCK;
            sel_d        = surv_idx;
            locked_d     = 1'b1;
            phase_d      = ph_nxt[surv_idx];
            frame_done_d = 1'b1;
          end
        end
      end
      LOCK: begin
        if (z_valid) begin
          if (sym_nxt[sel_q] == z) begin
            cph_d[sel_q] = ph_nxt[sel_q];
            phase_d      = ph_nxt[sel_q];
            frame_done_d = at_end[sel_q];
          end else begin
            // sel is left holding the sequence that was lost.
            state_d  = HUNT;
            mask_d   = '0;
            locked_d = 1'b0;
            phase_d  = 4'd0;
            err_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d  = HUNT;
        mask_d   = '0;
        locked_d = 1'b0;
        phase_d  = 4'd0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HUNT;
      mask_q       <= '0;
      cph_q        <= '0;
      sel_q        <= 2'd0;
      locked_q     <= 1'b0;
      phase_q      <= 4'd0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      cph_q        <= cph_d;
      sel_q        <= sel_d;
      locked_q     <= locked_d;
      phase_q      <= phase_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  assign sel        = sel_q;
  assign locked     = locked_q;
  assign phase      = phase_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;
endmodule

// File: tb/tb_seq_detector.sv
// Bench for seq_detector: directed scenarios plus random symbol streams,
// all compared against a history-based reference model.
module tb_seq_detector;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] z = 2'd0;
  logic       z_valid = 1'b0;
  logic [1:0] sel;
  logic       locked;
  logic [3:0] phase;
  logic       frame_done;
  logic       err;

  seq_detector dut (
    .clk        (clk),
    .rst        (rst),
    .z          (z),
    .z_valid    (z_valid),
    .sel        (sel),
    .locked     (locked),
    .phase      (phase),
    .frame_done (frame_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Sequence table, symbols listed from position 0.
  int tlen[4]    = '{12, 4, 6, 2};
  int tbl[4][12] = '{'{3,2,0,3,3,0,2,3,1,2,2,1},
                     '{1,3,2,0,0,0,0,0,0,0,0,0},
                     '{2,1,2,2,3,0,0,0,0,0,0,0},
                     '{1,2,0,0,0,0,0,0,0,0,0,0}};

  // Reference model: remembers the symbols of the current attempt and
  // rechecks every candidate against the whole history.
  int ms = 0;               // 0 hunt, 1 track, 2 lock
  int hist[$];
  int mn = 0;               // symbols accepted in the current attempt
  int msel = 0, mlock = 0, mph = 0, mfd = 0, merr = 0;

  function automatic bit alive(input int k);
    for (int i = 0; i < hist.size(); i++)
      if (hist[i] != tbl[k][i % tlen[k]]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(input int zz, input bit v, input bit r);
    int cnt, kk;
    if (r) begin
      ms = 0; hist.delete(); mn = 0;
      msel = 0; mlock = 0; mph = 0; mfd = 0; merr = 0;
      return;
    end
    mfd = 0; merr = 0;
    if (!v) return;
    case (ms)
      0: begin
        cnt = 0;
        for (int k = 0; k < 4; k++) if (tbl[k][0] == zz) cnt++;
        if (cnt > 0) begin
          hist.delete(); hist.push_back(zz); mn = 1; ms = 1;
        end
      end
      1: begin
        hist.push_back(zz); mn++;
        cnt = 0; kk = 0;
        for (int k = 0; k < 4; k++) if (alive(k)) begin cnt++; kk = k; end
        if (cnt == 0) begin
          ms = 0; merr = 1; hist.delete();
        end else if (cnt == 1 && ((mn - 1) % tlen[kk]) == tlen[kk] - 1) begin
          ms = 2; msel = kk; mlock = 1; mph = tlen[kk] - 1; mfd = 1;
        end
      end
      default: begin
        if (tbl[msel][mn % tlen[msel]] == zz) begin
          mn++;
          mph = (mn - 1) % tlen[msel];
          mfd = (mph == tlen[msel] - 1);
        end else begin
          ms = 0; mlock = 0; mph = 0; merr = 1; hist.delete();
        end
      end
    endcase
  endtask

  // One clock: drive at negedge, update model at posedge, compare after.
  task automatic step(input int zz, input bit v, input bit r);
    @(negedge clk);
    z = 2'(zz); z_valid = v; rst = r;
    @(posedge clk);
    model_step(zz, v, r);
    #1;
    chk("sel",        int'(sel),        msel);
    chk("locked",     int'(locked),     mlock);
    chk("phase",      int'(phase),      mph);
    chk("frame_done", int'(frame_done), mfd);
    chk("err",        int'(err),        merr);
  endtask

  task automatic feed(input int k, input int n);
    for (int i = 0; i < n; i++) step(tbl[k][i % tlen[k]], 1'b1, 1'b0);
  endtask

  initial begin
    int fk, fpos, zz;
    bit v, r;

    // Reset state.
    step(0, 1'b1, 1'b1);
    chk("rst_locked", int'(locked), 0);
    chk("rst_phase",  int'(phase), 0);

    // Two-symbol sequence locks immediately and frames every second symbol.
    step(1, 1'b1, 1'b0);
    step(2, 1'b1, 1'b0);
    chk("s3_sel", int'(sel), 3);
    chk("s3_fd",  int'(frame_done), 1);
    step(1, 1'b1, 1'b0);
    chk("s3_fd_mid", int'(frame_done), 0);
    step(2, 1'b1, 1'b0);
    chk("s3_fd_again", int'(frame_done), 1);

    // Four-symbol sequence, then a broken period.
    step(0, 1'b1, 1'b1);
    feed(1, 4);
    chk("s1_sel",   int'(sel), 1);
    chk("s1_phase", int'(phase), 3);
    step(1, 1'b1, 1'b0); step(3, 1'b1, 1'b0); step(2, 1'b1, 1'b0);
    step(2, 1'b1, 1'b0);
    chk("s1_err",    int'(err), 1);
    chk("s1_unlock", int'(locked), 0);
    chk("s1_selhold", int'(sel), 1);

    // Twelve-symbol sequence with gaps: lock only on the twelfth symbol.
    step(0, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) begin
      step(tbl[0][i], 1'b1, 1'b0);
      if (i < 11) chk("s0_early", int'(locked), 0);
      step(0, 1'b0, 1'b0);
    end
    chk("s0_locked_gap", int'(locked), 1);
    chk("s0_phase_gap",  int'(phase), 11);

    // Idle symbol in hunt is ignored; six-symbol sequence; reset mid-period.
    step(0, 1'b1, 1'b1);
    step(0, 1'b1, 1'b0);
    chk("hunt00_err", int'(err), 0);
    feed(2, 6);
    chk("s2_sel",   int'(sel), 2);
    chk("s2_phase", int'(phase), 5);
    feed(2, 3);
    step(3, 1'b1, 1'b1);
    chk("midrst_sel",    int'(sel), 0);
    chk("midrst_locked", int'(locked), 0);
    feed(2, 6);
    chk("relock", int'(locked), 1);

    // Broken start: 10 then 11 errors, next 10 restarts.
    step(0, 1'b1, 1'b1);
    step(2, 1'b1, 1'b0);
    step(3, 1'b1, 1'b0);
    chk("brk_err", int'(err), 1);
    feed(2, 6);
    chk("brk_relock", int'(sel), 2);

    // Random streams, mostly following some sequence with occasional noise.
    fk = 0; fpos = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) begin
        fk = $urandom_range(0, 3); fpos = 0;
      end
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) zz = $urandom_range(0, 3);
      else zz = tbl[fk][fpos % tlen[fk]];
      if (v) fpos++;
      step(zz, v, r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
